tlb_array: RTL and testbench

TLB_ARRAY -- requirements
Module: tlb_array

---
 rtl/tlb_array.sv | 225 ++++++++++++++++++++++
 tb/tb_tlb_array.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_array.sv
`default_nettype none
// ============================================================================
// Module      : tlb_array
// Description : TLB entry storage with one write port, a combinational read
//               port and two registered associative search ports (fetch/data).
//               Optional macro TLB_WRITE_FORWARD_EN forwards same-cycle write
//               data into searches.
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_array #(
    parameter int TLBNUM       = 16,
    parameter int TLBNUM_WIDTH = $clog2(TLBNUM)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [TLBNUM_WIDTH-1:0] w_index,
    input  logic [18:0]             w_vpn2,
    input  logic [7:0]              w_asid,
    input  logic                    w_g,
    input  logic [19:0]             w_pfn0,
    input  logic [2:0]              w_c0,
    input  logic                    w_d0,
    input  logic                    w_v0,
    input  logic [19:0]             w_pfn1,
    input  logic [2:0]              w_c1,
    input  logic                    w_d1,
    input  logic                    w_v1,
    input  logic [TLBNUM_WIDTH-1:0] r_index,
    output logic [18:0]             r_vpn2,
    output logic [7:0]              r_asid,
    output logic                    r_g,
    output logic [19:0]             r_pfn0,
    output logic [2:0]              r_c0,
    output logic                    r_d0,
    output logic                    r_v0,
    output logic [19:0]             r_pfn1,
    output logic [2:0]              r_c1,
    output logic                    r_d1,
    output logic                    r_v1,
    input  logic                    s0_req,
    input  logic [18:0]             s0_vpn2,
    input  logic                    s0_odd_page,
    input  logic [7:0]              s0_asid,
    output logic                    s0_done,
    output logic                    s0_found,
    output logic [TLBNUM_WIDTH-1:0] s0_index,
    output logic [19:0]             s0_pfn,
    output logic [2:0]              s0_c,
    output logic                    s0_d,
    output logic                    s0_v,
    output logic                    s0_multi,
    input  logic                    s1_req,
    input  logic [18:0]             s1_vpn2,
    input  logic                    s1_odd_page,
    input  logic [7:0]              s1_asid,
    output logic                    s1_done,
    output logic                    s1_found,
    output logic [TLBNUM_WIDTH-1:0] s1_index,
    output logic [19:0]             s1_pfn,
    output logic [2:0]              s1_c,
    output logic                    s1_d,
    output logic                    s1_v,
    output logic                    s1_multi,
    output logic [TLBNUM_WIDTH:0]   s1_probe
);

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } entry_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic        odd_page;
        logic [7:0]  asid;
    } key_t;

    typedef struct packed {
        logic                    found;
        logic [TLBNUM_WIDTH-1:0] index;
        logic [19:0]             pfn;
        logic [2:0]              c;
        logic                    d;
        logic                    v;
        logic                    multi;
    } result_t;

    localparam int c_NUM_PORTS = 2;

    entry_t                   r_tlb  [TLBNUM];
    entry_t                   w_view [TLBNUM];
    entry_t                   w_wr_entry;
    entry_t                   w_rd_entry;
    key_t                     w_key  [c_NUM_PORTS];
    logic [c_NUM_PORTS-1:0]   w_req;
    result_t                  w_res  [c_NUM_PORTS];
    logic [c_NUM_PORTS-1:0]   r_done;
    result_t                  r_res  [c_NUM_PORTS];
    logic [TLBNUM_WIDTH:0]    r_probe;

    assign w_wr_entry = '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                          pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                          pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};

    assign w_key[0] = '{vpn2: s0_vpn2, odd_page: s0_odd_page, asid: s0_asid};
    assign w_key[1] = '{vpn2: s1_vpn2, odd_page: s1_odd_page, asid: s1_asid};
    assign w_req    = {s1_req, s0_req};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TLBNUM; i++) begin
                r_tlb[i] <= '0;
            end
        end else if (we) begin
            r_tlb[w_index] <= w_wr_entry;
        end
    end

    assign w_rd_entry = r_tlb[r_index];
    assign r_vpn2 = w_rd_entry.vpn2;
    assign r_asid = w_rd_entry.asid;
    assign r_g    = w_rd_entry.g;
    assign r_pfn0 = w_rd_entry.pfn0;
    assign r_c0   = w_rd_entry.c0;
    assign r_d0   = w_rd_entry.d0;
    assign r_v0   = w_rd_entry.v0;
    assign r_pfn1 = w_rd_entry.pfn1;
    assign r_c1   = w_rd_entry.c1;
    assign r_d1   = w_rd_entry.d1;
    assign r_v1   = w_rd_entry.v1;

    // The view searched this cycle: stored contents, optionally overlaid with the pending write.
    for (genvar i = 0; i < TLBNUM; i++) begin : g_entry
`ifdef TLB_WRITE_FORWARD_EN
        assign w_view[i] = (we && (w_index == TLBNUM_WIDTH'(i))) ? w_wr_entry : r_tlb[i];
`else
        assign w_view[i] = r_tlb[i];
`endif
    end

    for (genvar p = 0; p < c_NUM_PORTS; p++) begin : g_port
        result_t w_lookup;
        entry_t  w_sel;

        always_comb begin
            w_lookup = '0;
            w_sel    = '0;
            for (int i = 0; i < TLBNUM; i++) begin
                if ((w_view[i].vpn2 == w_key[p].vpn2) &&
                    (w_view[i].g || (w_view[i].asid == w_key[p].asid))) begin
                    if (w_lookup.found) begin
                        w_lookup.multi = 1'b1;
                    end else begin
                        w_lookup.found = 1'b1;
                        w_lookup.index = TLBNUM_WIDTH'(i);
                    end
                end
            end
            if (w_lookup.found) begin
                w_sel = w_view[w_lookup.index];
                if (w_key[p].odd_page) begin
                    {w_lookup.pfn, w_lookup.c, w_lookup.d, w_lookup.v} =
                        {w_sel.pfn1, w_sel.c1, w_sel.d1, w_sel.v1};
                end else begin
                    {w_lookup.pfn, w_lookup.c, w_lookup.d, w_lookup.v} =
                        {w_sel.pfn0, w_sel.c0, w_sel.d0, w_sel.v0};
                end
            end
        end

        assign w_res[p] = w_lookup;
    end

    // Results update only on an accepted request and otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done  <= '0;
            r_probe <= '0;
            for (int n = 0; n < c_NUM_PORTS; n++) begin
                r_res[n] <= '0;
            end
        end else begin
            r_done <= w_req;
            for (int n = 0; n < c_NUM_PORTS; n++) begin
                if (w_req[n]) begin
                    r_res[n] <= w_res[n];
                end
            end
            if (w_req[1]) begin
                r_probe <= {~w_res[1].found, w_res[1].index};
            end
        end
    end

    assign s0_done  = r_done[0];
    assign s0_found = r_res[0].found;
    assign s0_index = r_res[0].index;
    assign s0_pfn   = r_res[0].pfn;
    assign s0_c     = r_res[0].c;
    assign s0_d     = r_res[0].d;
    assign s0_v     = r_res[0].v;
    assign s0_multi = r_res[0].multi;

    assign s1_done  = r_done[1];
    assign s1_found = r_res[1].found;
    assign s1_index = r_res[1].index;
    assign s1_pfn   = r_res[1].pfn;
    assign s1_c     = r_res[1].c;
    assign s1_d     = r_res[1].d;
    assign s1_v     = r_res[1].v;
    assign s1_multi = r_res[1].multi;
    assign s1_probe = r_probe;

endmodule
`default_nettype wire

// File: tb/tb_tlb_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlb_array
// Description : Self-checking bench for tlb_array: directed scenarios plus
//               randomized traffic compared against a behavioural TLB model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlb_array;

    localparam int N = 16;
    localparam int W = $clog2(N);

    logic clk = 1'b0;
    logic reset;
    logic we;
    logic [W-1:0] w_index, r_index;
    logic [18:0] w_vpn2, r_vpn2;
    logic [7:0]  w_asid, r_asid;
    logic        w_g, r_g;
    logic [19:0] w_pfn0, w_pfn1, r_pfn0, r_pfn1;
    logic [2:0]  w_c0, w_c1, r_c0, r_c1;
    logic        w_d0, w_v0, w_d1, w_v1, r_d0, r_v0, r_d1, r_v1;
    logic        s0_req, s0_odd_page, s1_req, s1_odd_page;
    logic [18:0] s0_vpn2, s1_vpn2;
    logic [7:0]  s0_asid, s1_asid;
    logic        s0_done, s0_found, s0_d, s0_v, s0_multi;
    logic        s1_done, s1_found, s1_d, s1_v, s1_multi;
    logic [W-1:0] s0_index, s1_index;
    logic [19:0] s0_pfn, s1_pfn;
    logic [2:0]  s0_c, s1_c;
    logic [W:0]  s1_probe;

    int n_vec  = 0;
    int n_miss = 0;

    tlb_array #(.TLBNUM(N)) dut (
        .clk(clk), .reset(reset), .we(we), .w_index(w_index),
        .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
        .s0_req(s0_req), .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
        .s0_done(s0_done), .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
        .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v), .s0_multi(s0_multi),
        .s1_req(s1_req), .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
        .s1_done(s1_done), .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
        .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v), .s1_multi(s1_multi),
        .s1_probe(s1_probe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [18:0] vpn2; logic [7:0] asid; logic g;
        logic [19:0] pfn0; logic [2:0] c0; logic d0; logic v0;
        logic [19:0] pfn1; logic [2:0] c1; logic d1; logic v1;
    } ent_t;

    typedef struct packed {
        logic done; logic found; logic [W-1:0] index;
        logic [19:0] pfn; logic [2:0] c; logic d; logic v; logic multi;
    } res_t;

    ent_t mem  [N];
    ent_t view [N];
    res_t exp_s [2];
    logic [W:0] exp_probe;

    function automatic res_t lookup(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
        res_t r;
        int   hits[$];
        int   h;
        ent_t e;
        r = '0;
        for (int i = 0; i < N; i++)
            if (view[i].vpn2 == vpn2 && (view[i].g || view[i].asid == asid))
                hits.push_back(i);
        if (hits.size() > 0) begin
            h       = hits[0];
            e       = view[h];
            r.found = 1'b1;
            r.index = h[W-1:0];
            r.multi = (hits.size() > 1);
            if (odd) begin r.pfn = e.pfn1; r.c = e.c1; r.d = e.d1; r.v = e.v1; end
            else     begin r.pfn = e.pfn0; r.c = e.c0; r.d = e.d0; r.v = e.v0; end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        ent_t wnew;
        if (reset) begin
            for (int i = 0; i < N; i++) mem[i] = '0;
            exp_s[0]  = '0;
            exp_s[1]  = '0;
            exp_probe = '0;
        end else begin
            wnew = '{vpn2: w_vpn2, asid: w_asid, g: w_g, pfn0: w_pfn0, c0: w_c0, d0: w_d0,
                     v0: w_v0, pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};
            for (int i = 0; i < N; i++) view[i] = mem[i];
`ifdef TLB_WRITE_FORWARD_EN
            if (we) view[w_index] = wnew;
`endif
            if (s0_req) exp_s[0] = lookup(s0_vpn2, s0_odd_page, s0_asid);
            exp_s[0].done = s0_req;
            if (s1_req) begin
                exp_s[1]  = lookup(s1_vpn2, s1_odd_page, s1_asid);
                exp_probe = {~exp_s[1].found, exp_s[1].index};
            end
            exp_s[1].done = s1_req;
            if (we) mem[w_index] = wnew;
        end
    end

    // Compare every cycle, shortly after the active edge.
    always @(posedge clk) begin
        ent_t rd;
        #1;
        check("s0_done",  s0_done,  exp_s[0].done);
        check("s0_found", s0_found, exp_s[0].found);
        check("s0_index", s0_index, exp_s[0].index);
        check("s0_page",  {s0_pfn, s0_c, s0_d, s0_v}, {exp_s[0].pfn, exp_s[0].c, exp_s[0].d, exp_s[0].v});
        check("s0_multi", s0_multi, exp_s[0].multi);
        check("s1_done",  s1_done,  exp_s[1].done);
        check("s1_found", s1_found, exp_s[1].found);
        check("s1_index", s1_index, exp_s[1].index);
        check("s1_page",  {s1_pfn, s1_c, s1_d, s1_v}, {exp_s[1].pfn, exp_s[1].c, exp_s[1].d, exp_s[1].v});
        check("s1_multi", s1_multi, exp_s[1].multi);
        check("s1_probe", s1_probe, exp_probe);
        rd = mem[r_index];
        check("read_port", {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1}, rd);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        we = 1'b0; s0_req = 1'b0; s1_req = 1'b0;
    endtask

    task automatic drive_write(input int idx, input logic [18:0] vpn2, input logic [7:0] asid, input logic g,
                               input logic [19:0] pfn0, input logic v0,
                               input logic [19:0] pfn1, input logic d1, input logic v1);
        we = 1'b1; w_index = idx[W-1:0]; w_vpn2 = vpn2; w_asid = asid; w_g = g;
        w_pfn0 = pfn0; w_c0 = 3'd0; w_d0 = 1'b0; w_v0 = v0;
        w_pfn1 = pfn1; w_c1 = 3'd0; w_d1 = d1; w_v1 = v1;
    endtask

    task automatic drive_search(input int port, input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
        if (port == 0) begin s0_req = 1'b1; s0_vpn2 = vpn2; s0_odd_page = odd; s0_asid = asid; end
        else           begin s1_req = 1'b1; s1_vpn2 = vpn2; s1_odd_page = odd; s1_asid = asid; end
    endtask

    function automatic logic [18:0] pick_vpn();
        case ($urandom_range(0, 4))
            0:       return 19'h00100;
            1:       return 19'h12345;
            2:       return 19'h7FFFF;
            3:       return 19'h00000;
            default: return 19'($urandom);
        endcase
    endfunction

    logic [18:0] k0 [4];
    logic [18:0] k1 [4];
    logic        f0 [4];
    logic        f1 [4];
    logic [W-1:0] i0 [4];
    logic [W-1:0] i1 [4];

    initial begin
        reset = 1'b1;
        idle();
        w_index = '0; w_vpn2 = '0; w_asid = '0; w_g = 1'b0;
        w_pfn0 = '0; w_c0 = '0; w_d0 = 1'b0; w_v0 = 1'b0;
        w_pfn1 = '0; w_c1 = '0; w_d1 = 1'b0; w_v1 = 1'b0;
        r_index = '0;
        s0_vpn2 = '0; s0_odd_page = 1'b0; s0_asid = '0;
        s1_vpn2 = '0; s1_odd_page = 1'b0; s1_asid = '0;
        repeat (3) tick();
        check("rst_s0_done", s0_done, 1'b0);
        check("rst_s1_found", s1_found, 1'b0);
        check("rst_s1_probe", s1_probe, 0);
        check("rst_r_v0", r_v0, 1'b0);
        reset = 1'b0;

        // Zeroed array: key 0/0 hits entry 0 with an invalid page.
        drive_search(0, 19'h0, 1'b0, 8'h00); tick(); idle();
        check("zero_done", s0_done, 1'b1);
        check("zero_found", s0_found, 1'b1);
        check("zero_index", s0_index, 0);
        check("zero_v", s0_v, 1'b0);

        drive_write(3, 19'h12345, 8'h07, 1'b0, 20'h00ABC, 1'b1, 20'h00DEF, 1'b1, 1'b1); tick(); idle();
        drive_search(0, 19'h12345, 1'b1, 8'h07); tick(); idle();
        check("e3_done", s0_done, 1'b1);
        check("e3_found", s0_found, 1'b1);
        check("e3_index", s0_index, 3);
        check("e3_pfn", s0_pfn, 20'h00DEF);
        check("e3_dv", {s0_d, s0_v}, 2'b11);
        tick();
        check("e3_done_drop", s0_done, 1'b0);
        check("e3_hold_pfn", s0_pfn, 20'h00DEF);

        drive_search(1, 19'h12345, 1'b0, 8'h08); tick(); idle();
        check("asid_miss_found", s1_found, 1'b0);
        check("asid_miss_probe", s1_probe, 1 << W);
        drive_write(3, 19'h12345, 8'h07, 1'b1, 20'h00ABC, 1'b1, 20'h00DEF, 1'b1, 1'b1); tick(); idle();
        drive_search(1, 19'h12345, 1'b0, 8'h08); tick(); idle();
        check("global_found", s1_found, 1'b1);
        check("global_probe", s1_probe, 3);
        check("global_pfn", s1_pfn, 20'h00ABC);

        drive_write(2, 19'h00100, 8'h00, 1'b1, 20'h00222, 1'b1, 20'h0, 1'b0, 1'b0); tick();
        drive_write(5, 19'h00100, 8'h00, 1'b1, 20'h00555, 1'b1, 20'h0, 1'b0, 1'b0); tick(); idle();
        drive_search(0, 19'h00100, 1'b0, 8'h33); tick(); idle();
        check("multi_index", s0_index, 2);
        check("multi_flag", s0_multi, 1'b1);
        check("multi_pfn", s0_pfn, 20'h00222);

        drive_write(4, 19'h7FFFF, 8'h11, 1'b1, 20'h00444, 1'b1, 20'h0, 1'b0, 1'b0);
        drive_search(0, 19'h7FFFF, 1'b0, 8'h11); tick(); idle();
`ifdef TLB_WRITE_FORWARD_EN
        check("fwd_found", s0_found, 1'b1);
        check("fwd_index", s0_index, 4);
        check("fwd_pfn", s0_pfn, 20'h00444);
`else
        check("prewrite_found", s0_found, 1'b0);
        check("prewrite_index", s0_index, 0);
        check("prewrite_pfn", s0_pfn, 0);
`endif

        k0 = '{19'h12345, 19'h00100, 19'h7FFFF, 19'h55555};
        k1 = '{19'h55555, 19'h7FFFF, 19'h00100, 19'h12345};
        f0 = '{1'b1, 1'b1, 1'b1, 1'b0};
        f1 = '{1'b0, 1'b1, 1'b1, 1'b1};
        i0 = '{W'(3), W'(2), W'(4), W'(0)};
        i1 = '{W'(0), W'(4), W'(2), W'(3)};
        for (int k = 0; k < 4; k++) begin
            drive_search(0, k0[k], 1'b0, 8'h11);
            drive_search(1, k1[k], 1'b0, 8'h11);
            tick();
            check("b2b_done", {s0_done, s1_done}, 2'b11);
            check("b2b_found0", s0_found, f0[k]);
            check("b2b_index0", s0_index, i0[k]);
            check("b2b_found1", s1_found, f1[k]);
            check("b2b_index1", s1_index, i1[k]);
        end
        idle(); tick();
        check("b2b_end_done", {s0_done, s1_done}, 2'b00);

        for (int c = 0; c < 400; c++) begin
            reset   = ($urandom_range(0, 63) == 0);
            we      = $urandom_range(0, 1);
            w_index = W'($urandom);
            w_vpn2  = pick_vpn();
            w_asid  = 8'($urandom_range(0, 3));
            w_g     = ($urandom_range(0, 3) == 0);
            {w_pfn0, w_c0, w_d0, w_v0} = 25'($urandom);
            {w_pfn1, w_c1, w_d1, w_v1} = 25'($urandom);
            r_index = W'($urandom);
            s0_req  = $urandom_range(0, 1);
            s0_vpn2 = pick_vpn(); s0_odd_page = $urandom_range(0, 1); s0_asid = 8'($urandom_range(0, 3));
            s1_req  = $urandom_range(0, 1);
            s1_vpn2 = pick_vpn(); s1_odd_page = $urandom_range(0, 1); s1_asid = 8'($urandom_range(0, 3));
            tick();
        end
        reset = 1'b0; idle(); tick();

        // Reset in the middle of a request stream.
        drive_write(6, 19'h0ABCD, 8'h00, 1'b1, 20'h00666, 1'b1, 20'h0, 1'b0, 1'b0); tick(); idle();
        r_index = W'(6);
        drive_search(0, 19'h0ABCD, 1'b0, 8'h00);
        drive_search(1, 19'h0ABCD, 1'b0, 8'h00);
        tick();
        check("pre_rst_done", s0_done, 1'b1);
        check("pre_rst_r_v0", r_v0, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("async_s0_done", s0_done, 1'b0);
        check("async_s0_res", {s0_found, s0_index, s0_pfn, s0_v}, 0);
        check("async_s1_probe", s1_probe, 0);
        check("async_r_v0", r_v0, 1'b0);
        tick();
        reset = 1'b0; idle(); tick();
        check("post_rst_done", s0_done, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
